// File: rtl/truth_table_sweeper.sv
// Sweeps all eight input rows of a 3-input gate, samples its output after a settle
// time, and compares the assembled hex truth-table code against a latched expectation.
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       expected,
    input  logic             gate_out,
    output logic             in1,
    output logic             in2,
    output logic             in3,
    output logic             busy,
    output logic             done,
    output logic [7:0]       table_out,
    output logic [7:0]       mismatch_mask,
    output logic             match,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        IDLE,
        ROW,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       work_q, work_d;
    logic [7:0]       exp_q, exp_d;
    logic [2:0]       in_q, in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       table_q, table_d;
    logic [7:0]       mask_q, mask_d;
    logic             match_q, match_d;
    logic [7:0]       err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            work_q  <= 8'h00;
            exp_q   <= 8'h00;
            in_q    <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= 8'h00;
            mask_q  <= 8'h00;
            match_q <= 1'b0;
            err_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            exp_q   <= exp_d;
            in_q    <= in_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            mask_q  <= mask_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    // Result registers load on the edge entering DONE so they are already valid while done=1.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        exp_d   = exp_q;
        table_d = table_q;
        mask_d  = mask_q;
        match_d = match_q;
        err_d   = err_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = ROW;
                    exp_d   = expected;
                    work_d  = 8'h00;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end
            end
            ROW: begin
                if (cnt_q == SETTLE) begin
                    work_d[3'd7 - idx_q] = gate_out;
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
                        table_d = work_d;
                        mask_d  = work_d ^ exp_q;
                        match_d = (work_d == exp_q);
                        if ((work_d != exp_q) && (err_q != 8'hFF)) begin
                            err_d = err_q + 8'd1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = IDLE;
        endcase

        in_d   = (state_d == ROW) ? idx_d : 3'b000;
        busy_d = (state_d == ROW);
        done_d = (state_d == DONE);
    end

    assign {in1, in2, in3} = in_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign table_out       = table_q;
    assign mismatch_mask   = mask_q;
    assign match           = match_q;
    assign err_count       = err_q;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that characterises one 3-input combinational gate, such as a Cello hex-named truth-table module. It drives all eight input combinations in order and waits a programmable settle time per row. It samples the gate output and assembles the measured 8-bit truth-table code in the same hex convention used to name the gate modules. It then compares that code against an expected value and reports pass/fail. It sits between a test/config host and one gate instance, and owns the gate's three inputs for the duration of a sweep.

## Interface
- SETTLE_CYCLES, 2: extra cycles each input row is held before the gate output is sampled. Legal range 0..15.
- CNT_W, 4: width of the internal settle counter. Must hold SETTLE_CYCLES.

- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  sweep request. Accepted only when busy=0.
- expected  input  8  expected truth-table code. Latched on an accepted start.
- gate_out  input  1  output of the gate under test.
- in1, in2, in3  output  1 each  drive to the gate inputs. in1 is the MSB of the row index.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  8  measured truth-table code.
- mismatch_mask  output  8  table_out XOR latched expected.
- match  output  1  mismatch_mask == 0.
- err_count  output  8  number of completed sweeps with match=0. Saturates at 255.

## Operation
- Row index idx is 3 bits, 0..7. Inputs are driven as {in1,in2,in3} = idx.
- Bit mapping: gate_out sampled at row idx is written to table_out[7-idx]. Row 000 maps to the MSB, row 111 to the LSB. A correct gate therefore yields exactly its hex name; for example, the 0xC7 gate gives table_out=8'hC7.
- States:
  - IDLE: busy=0 and inputs=000. On start, latch expected, clear the working table and set idx=0. Go to ROW.
  - ROW: inputs=idx and the settle counter counts 0..SETTLE_CYCLES. In the cycle where counter==SETTLE_CYCLES, sample gate_out into the working table. If idx==7, go to DONE. Otherwise increment idx, clear the counter and stay in ROW.
  - DONE: lasts one cycle. done=1 and busy=0. table_out, mismatch_mask and match are updated from the working table. err_count increments if there was a mismatch and err_count<255. Go to IDLE, or straight to ROW if start=1 in this cycle.
- All outputs are registered.
- table_out, mismatch_mask and match change only in the DONE cycle. They hold their values until the next DONE or reset.
- start while busy=1 is ignored, with no queuing. expected is sampled only on an accepted start.
- Reset values of all outputs are 0: in1..in3=000, busy=0, done=0, table_out=0, mismatch_mask=0, match=0, err_count=0. State=IDLE.
- Reset mid-sweep aborts the sweep: no done pulse, and err_count is cleared.

## Timing
- start is accepted at the edge ending cycle N. busy=1 from cycle N+1. Row idx occupies cycles N+1+idx·(S+1) through N+(idx+1)·(S+1), where S=SETTLE_CYCLES.
- gate_out is sampled at the edge ending the last cycle of each row. The gate therefore sees stable inputs for S+1 cycles before sampling.
- done=1 and busy=0 in cycle N+8(S+1)+1. With S=2 that is cycle N+25; with S=0 it is cycle N+9.
- Back-to-back sweeps: a start in the DONE cycle begins row 0 in the following cycle. The new expected is latched. Period is 8(S+1)+1 cycles.
- Inputs are driven to 000 in IDLE and DONE, unless DONE immediately restarts, in which case row 0 = 000 anyway.

## Test plan
- Gate model = 0xC7 truth table, S=2, expected=8'hC7, start at cycle 10 -> inputs step 000..111, each held 3 cycles. done at cycle 35, table_out=8'hC7, mismatch_mask=0, match=1, err_count=0.
- Gate stuck-at-0, expected=8'hC7 -> table_out=8'h00, mismatch_mask=8'hC7, match=0, err_count=1. A second sweep gives err_count=2.
- Gate with 2-cycle output delay (0xC7 function): S=2 gives match=1; S=0 gives match=0 with a nonzero mismatch_mask.
- start pulsed repeatedly while busy, and expected changed mid-sweep -> single done pulse, and comparison uses the expected latched at acceptance.
- rst_n=0 for 1 cycle during row 4 -> next cycle busy=0, inputs=000, all outputs 0, no done pulse. A fresh start then completes normally.
- start held high continuously, S=0 -> done pulses every 9 cycles and err_count saturates at 255 after 255 failing sweeps, then stays at 255.
